// File: rtl/microsecond_timer.sv
// Interval timer driven by the free-running microsecond count. It produces one-shot
// or periodic expiry pulses, an elapsed-time readout and a saturating missed-period count.
module microsecond_timer #(
  parameter int P_COUNTER_WIDTH = 32,
  parameter int P_MISS_WIDTH    = 8
) (
  input  logic                       i_input_clk,
  input  logic                       i_nreset,
  input  logic [P_COUNTER_WIDTH-1:0] i_microsec_count,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [P_COUNTER_WIDTH-1:0] i_interval,
  input  logic                       i_periodic,
  output logic                       o_busy,
  output logic                       o_expire,
  output logic                       o_done,
  output logic [P_COUNTER_WIDTH-1:0] o_elapsed,
  output logic [P_MISS_WIDTH-1:0]    o_missed
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [P_MISS_WIDTH-1:0] LP_MISS_MAX = '1;
  localparam logic [P_MISS_WIDTH-1:0] LP_MISS_ONE = P_MISS_WIDTH'(1);

  state_t                       r_state;
  state_t                       w_state_next;
  logic [P_COUNTER_WIDTH-1:0]   r_base;
  logic [P_COUNTER_WIDTH-1:0]   w_base_next;
  logic [P_COUNTER_WIDTH-1:0]   r_interval;
  logic [P_COUNTER_WIDTH-1:0]   w_interval_next;
  logic                         r_periodic;
  logic                         w_periodic_next;
  logic                         r_expire;
  logic                         w_expire_next;
  logic                         r_done;
  logic                         w_done_next;
  logic [P_COUNTER_WIDTH-1:0]   r_elapsed;
  logic [P_COUNTER_WIDTH-1:0]   w_elapsed_next;
  logic [P_MISS_WIDTH-1:0]      r_missed;
  logic [P_MISS_WIDTH-1:0]      w_missed_next;

  logic [P_COUNTER_WIDTH-1:0]   w_elapsed;
  logic                         w_due;
  logic                         w_lagging;

  // Modular subtraction keeps elapsed correct across count rollover.
  assign w_elapsed = i_microsec_count - r_base;
  assign w_due     = (r_state == ST_RUN) && (w_elapsed >= r_interval);
  // Compare against 2*interval with one extra bit so the doubling cannot overflow.
  assign w_lagging = {1'b0, w_elapsed} >= {r_interval, 1'b0};

  always_comb begin
    w_state_next    = r_state;
    w_base_next     = r_base;
    w_interval_next = r_interval;
    w_periodic_next = r_periodic;
    w_expire_next   = 1'b0;
    w_done_next     = r_done;
    w_missed_next   = r_missed;
    w_elapsed_next  = r_elapsed;

    if (r_state == ST_RUN) begin
      w_elapsed_next = w_elapsed;
    end

    if (i_stop) begin
      w_state_next = ST_IDLE;
    end else if (i_start) begin
      w_state_next    = ST_RUN;
      w_base_next     = i_microsec_count;
      w_interval_next = i_interval;
      w_periodic_next = i_periodic && (i_interval != '0);
      w_done_next     = 1'b0;
      w_missed_next   = '0;
    end else if (w_due) begin
      w_expire_next = 1'b1;
      if (r_periodic) begin
        // Reload from the old base rather than the live count so periods never drift.
        w_base_next = r_base + r_interval;
        if (w_lagging && (r_missed != LP_MISS_MAX)) begin
          w_missed_next = r_missed + LP_MISS_ONE;
        end
      end else begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_input_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_interval <= '0;
      r_periodic <= 1'b0;
      r_expire   <= 1'b0;
      r_done     <= 1'b0;
      r_elapsed  <= '0;
      r_missed   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_base     <= w_base_next;
      r_interval <= w_interval_next;
      r_periodic <= w_periodic_next;
      r_expire   <= w_expire_next;
      r_done     <= w_done_next;
      r_elapsed  <= w_elapsed_next;
      r_missed   <= w_missed_next;
    end
  end

  assign o_busy    = (r_state == ST_RUN);
  assign o_expire  = r_expire;
  assign o_done    = r_done;
  assign o_elapsed = r_elapsed;
  assign o_missed  = r_missed;

endmodule

// File: doc/microsecond_timer.md
Name: microsecond_timer

Overview:
- Programmable interval timer directly downstream of the microsecond counter.
- Consumes the free-running microsecond count and produces one-shot or periodic expiry pulses plus an elapsed-time readout for the fss control logic.
- Everything runs on the same input clock as the counter, so no clock-domain crossing is needed.
- All timing uses modulo-2^W arithmetic, so counter wrap-around is transparent.

Parameters:
- P_COUNTER_WIDTH, 32: width W of the incoming count, the interval, and the elapsed output.
- P_MISS_WIDTH, 8: width of the saturating missed-period counter.

Ports:
- I_INPUT_CLK  in  1  system clock, same clock as the upstream microsecond counter.
- I_NRESET  in  1  asynchronous active-low reset.
- I_MICROSEC_COUNT  in  W  free-running microsecond count from the upstream counter; increments by at most 1 per clock.
- I_START  in  1  single-cycle request; arms or re-arms the timer.
- I_STOP  in  1  single-cycle request; disarms the timer.
- I_INTERVAL  in  W  interval in microseconds; sampled only on an accepted start.
- I_PERIODIC  in  1  1 = auto-reload, 0 = one-shot; sampled only on an accepted start.
- O_BUSY  out  1  timer is armed.
- O_EXPIRE  out  1  one-cycle pulse on each expiry.
- O_DONE  out  1  sticky flag: a one-shot has completed.
- O_ELAPSED  out  W  microseconds elapsed since the current period base.
- O_MISSED  out  P_MISS_WIDTH  saturating count of periods lost to catch-up.

Behaviour:
- Reset (async, I_NRESET=0) forces:
  - state=IDLE;
  - O_BUSY=0, O_EXPIRE=0, O_DONE=0;
  - O_ELAPSED=0, O_MISSED=0;
  - internal base=0, interval=0, periodic=0.
- Reset mid-run aborts the timer silently, with no expire pulse.
- States: IDLE, RUN.
- Request priority: I_STOP beats I_START in the same cycle. The stop wins and the state goes to IDLE.
- Accepted start (state IDLE or RUN, I_STOP=0), on that clock edge:
  - base <= I_MICROSEC_COUNT;
  - interval <= I_INTERVAL;
  - periodic <= I_PERIODIC;
  - O_DONE <= 0, O_MISSED <= 0;
  - state <= RUN, and O_BUSY=1 from the next cycle.
  - A start while in RUN restarts the timer and discards the old period with no pulse.
- Zero interval (I_INTERVAL=0 on start): always treated as one-shot, regardless of I_PERIODIC. O_EXPIRE pulses in the cycle after the start, then state=IDLE and O_DONE=1.
- Elapsed calculation in RUN:
  - elapsed = (I_MICROSEC_COUNT - base) mod 2^W, computed combinationally.
  - O_ELAPSED is registered as elapsed, giving 1-cycle latency.
  - In IDLE, O_ELAPSED holds its last value.
- Expiry condition: in RUN with elapsed >= interval. O_EXPIRE is registered and is high for exactly one cycle, on the cycle after the condition is first seen.
- One-shot expiry:
  - state <= IDLE, O_BUSY <= 0, O_DONE <= 1.
  - O_DONE stays set until the next accepted start or reset.
- Periodic expiry:
  - base <= base + interval (mod 2^W). Reloading from the base, not the live count, prevents drift.
  - State stays RUN.
  - If elapsed >= 2*interval at the moment of expiry, O_MISSED increments (saturating at all-ones). Only one O_EXPIRE pulse is emitted per clock; catch-up pulses then follow on consecutive cycles.
- I_STOP while in RUN: state <= IDLE, O_BUSY <= 0, no pulse, O_DONE unchanged.
- Wrap-around: modular subtraction gives correct elapsed across count rollover for any interval up to 2^W-1.
- Upstream counter reset while in RUN: the count goes backwards, elapsed becomes huge, and expiry fires. This is the defined behaviour; system logic must reset both blocks together.
- Single registered always block plus one combinational subtractor/comparator. No multi-cycle paths.

Test Plan:
- Reset mid-run: start (interval 10), assert I_NRESET=0 at elapsed 4 → all outputs 0 immediately; no O_EXPIRE afterward.
- One-shot:
  - Stimulus: I_INTERVAL=5, I_PERIODIC=0, start at count=100.
  - Required: O_EXPIRE is one 1-cycle pulse on the cycle after count reaches 105; then O_BUSY=0, O_DONE=1; O_ELAPSED=5.
- Periodic, no drift: interval 3, start at count=0 → pulses after counts 3, 6, 9, 12; O_MISSED=0.
- Wrap: W=8, start at count=250, interval 10 → pulse after count wraps to 4; O_ELAPSED=10 at expiry.
- Stop/start priority and restart:
  - I_STOP and I_START both high in RUN → IDLE, no pulse.
  - A start at elapsed 7 with a new interval 20 → next pulse 20 µs after the restart count.
- Zero interval and catch-up:
  - I_INTERVAL=0, I_PERIODIC=1 → exactly one pulse, then IDLE with O_DONE=1.
  - Periodic interval 2 with I_MICROSEC_COUNT forced to jump by 7 → back-to-back pulses, and O_MISSED increments.
